// File: rtl/clmul_acc_8bit.sv
// clmul_acc_8bit: accumulates the XOR of truncated GF(2) 8x8 carry-less
// products over a valid/ready burst and emits the sum, beat count and
// overflow flag once the burst's last beat has been absorbed.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      operand handshake (in_a, in_b, in_last)
//   out_valid/out_ready    result handshake (out_y, out_count, out_ovf)
module clmul_acc_8bit #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_y,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Low byte of the carry-less product; degree >= 8 terms fall away.
  function automatic logic [7:0] clmul8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i <= k; i++) begin
        p[k] = p[k] ^ (a[i] & b[k-i]);
      end
    end
    return p;
  endfunction

  state_t           r_state;
  state_t           w_state_nx;

  logic [7:0]       r_s1_a;
  logic [7:0]       r_s1_b;
  logic             r_s1_last;
  logic             r_s1_v;
  logic [7:0]       r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_pend;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [7:0]       r_out_y;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_ovf;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_cnt_sat;
  logic [7:0]       w_acc_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_ovf_nx;
  logic             w_pend_nx;
  logic             w_rdy_nx;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;
  assign w_cnt_sat  = (r_cnt == {CNT_W{1'b1}});
  assign w_acc_nx   = r_acc ^ clmul8(r_s1_a, r_s1_b);
  assign w_cnt_nx   = w_cnt_sat ? r_cnt : r_cnt + 1'b1;
  assign w_ovf_nx   = r_ovf | w_cnt_sat;

  // A last beat stays "pending" from its acceptance until the result
  // leaves; this keeps in_ready low while it drains through s1.
  always_comb begin
    w_pend_nx = r_pend;
    if (w_out_xfer) begin
      w_pend_nx = 1'b0;
    end else if (w_in_xfer && in_last) begin
      w_pend_nx = 1'b1;
    end
  end

  assign w_rdy_nx = (w_state_nx == ACC) & ~w_pend_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ACC:  if (r_s1_v && r_s1_last) w_state_nx = DONE;
      DONE: if (w_out_xfer)          w_state_nx = ACC;
      default: w_state_nx = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_last   <= 1'b0;
      r_s1_v      <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_pend      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_s1_v     <= w_in_xfer;
      r_pend     <= w_pend_nx;
      r_in_ready <= w_rdy_nx;
      if (w_in_xfer) begin
        r_s1_a    <= in_a;
        r_s1_b    <= in_b;
        r_s1_last <= in_last;
      end
      if (w_out_xfer) begin
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovf       <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        if (r_s1_v) begin
          r_acc <= w_acc_nx;
          r_cnt <= w_cnt_nx;
          r_ovf <= w_ovf_nx;
          if (r_s1_last) begin
            r_out_y     <= w_acc_nx;
            r_out_count <= w_cnt_nx;
            r_out_ovf   <= w_ovf_nx;
          end
        end
        // Result is already latched; valid follows one edge later.
        if (r_state == DONE && !r_out_valid) begin
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_clmul_acc_8bit.sv
// tb_clmul_acc_8bit: directed and random bursts against a
// shift-and-xor reference product, CNT_W=2 so saturation is reachable.
module tb_clmul_acc_8bit;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_a;
  logic [7:0]    in_b;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_y;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  int ncmp = 0;
  int nerr = 0;

  logic [7:0] ba [16];
  logic [7:0] bb [16];

  always #5 clk = ~clk;

  clmul_acc_8bit #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Full 16-bit product by shift-and-xor, then keep the low byte.
  function automatic logic [7:0] ref_mul(input logic [7:0] a,
                                         input logic [7:0] b);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ ({8'h00, a} << i);
    end
    return r[7:0];
  endfunction

  // Sends ba/bb[0..n-1]; ey < 0 means take expectations from the model.
  task automatic burst(input int n, input bit gaps, input int hold,
                       input int ey, input int ec, input int eo);
    logic [7:0] my;
    int mc, mo, i, guard, k;
    bit xfer, seen;
    my = '0;
    for (int j = 0; j < n; j++) my = my ^ ref_mul(ba[j], bb[j]);
    mc = (n > 3) ? 3 : n;
    mo = (n > 3) ? 1 : 0;
    if (ey >= 0) begin
      my = ey[7:0];
      mc = ec;
      mo = eo;
    end
    i = 0;
    guard = 0;
    while (i < n) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid) begin
        in_a    = ba[i];
        in_b    = bb[i];
        in_last = (i == n - 1);
      end else begin
        in_a    = 8'($urandom);
        in_b    = 8'($urandom);
        in_last = 1'($urandom);
      end
      if (!gaps && i > 0) check("no_bubble", in_ready, 1);
      xfer = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (xfer) i++;
      guard++;
      if (guard > 500) begin
        check("in_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check("rdy_after_last", in_ready, 0);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 10) begin
      k++;
      @(posedge clk);
      #1;
      seen = out_valid;
    end
    check("latency", k, 2);
    if (!seen) return;
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", out_valid, 1);
      check("hold_y", out_y, my);
      check("hold_cnt", out_count, mc);
      check("hold_rdy", in_ready, 0);
      @(posedge clk);
      #1;
    end
    check("out_y", out_y, my);
    check("out_count", out_count, mc);
    check("out_ovf", out_ovf, mo);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_clr", out_valid, 0);
    check("rdy_back", in_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_y", out_y, 0);
    check("rst_cnt", out_count, 0);
    check("rst_ovf", out_ovf, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rdy_rise", in_ready, 1);

    ba[0] = 8'h03; bb[0] = 8'h03;
    burst(1, 0, 0, 'h05, 1, 0);
    ba[0] = 8'h80; bb[0] = 8'h02;
    burst(1, 0, 0, 'h00, 1, 0);
    ba[0] = 8'h0F; bb[0] = 8'h0F;
    burst(1, 0, 0, 'h55, 1, 0);

    ba[0] = 8'h03; bb[0] = 8'h03;
    ba[1] = 8'hFF; bb[1] = 8'h01;
    ba[2] = 8'h0F; bb[2] = 8'h0F;
    burst(3, 0, 5, 'hAF, 3, 0);

    for (int j = 0; j < 5; j++) begin
      ba[j] = 8'h01;
      bb[j] = 8'h01;
    end
    burst(5, 0, 1, 'h01, 3, 1);

    for (int j = 0; j < 2; j++) begin
      check("mid_rdy", in_ready, 1);
      in_valid = 1'b1;
      in_a     = 8'h3C;
      in_b     = 8'h5A;
      in_last  = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_rdy", in_ready, 0);
    @(posedge clk);
    #1;
    check("mid_rdy_rise", in_ready, 1);
    for (int j = 0; j < 4; j++) begin
      check("mid_no_valid", out_valid, 0);
      @(posedge clk);
      #1;
    end
    ba[0] = 8'h02; bb[0] = 8'h02;
    burst(1, 0, 0, 'h04, 1, 0);

    for (int t = 0; t < 30; t++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        ba[j] = 8'($urandom);
        bb[j] = 8'($urandom);
      end
      burst(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), -1, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/clmul_acc_8bit.md
CLMUL_ACC_8BIT -- requirements
Module: clmul_acc_8bit

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 5, the width of the beat counter and of out_count.
REQ-002 clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  Synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  An operand beat is offered.
REQ-005 in_ready  output  1  The block can accept a beat; a beat transfers on an edge where in_valid and in_ready are both 1.
REQ-006 in_a  input  8  Operand polynomial a, where bit i is the coefficient of x^i over GF(2).
REQ-007 in_b  input  8  Operand polynomial b, with the same encoding as in_a.
REQ-008 in_last  input  1  Marks the final beat of a burst; sampled only on a transfer.
REQ-009 out_valid  output  1  out_y, out_count and out_ovf are valid.
REQ-010 out_ready  input  1  The consumer accepts the result; the result transfers on an edge where out_valid and out_ready are both 1.
REQ-011 out_y  output  8  The XOR-accumulated truncated carry-less product of the burst.
REQ-012 out_count  output  CNT_W  The number of beats in the burst, saturating.
REQ-013 out_ovf  output  1  Set when the burst held more than 2^CNT_W-1 beats.

Function
REQ-014 The per-beat product SHALL be p[k] = XOR over i=0..k of (a[i] AND b[k-i]) for k=0..7; all terms of degree 8 and higher are discarded, and there is no modular reduction.
REQ-015 The block SHALL have an input register stage (s1_a, s1_b, s1_last, s1_v), an accumulator acc[7:0], a counter cnt[CNT_W-1:0], a sticky ovf bit, and a two-state FSM with states ACC and DONE.
REQ-016 in_ready SHALL be 1 only when the state is ACC and no beat marked in_last has been accepted and not yet retired; in_ready is registered logic and SHALL NOT depend combinationally on in_valid.
REQ-017 On each transfer, the block SHALL load in_a, in_b and in_last into the s1 registers and set s1_v to 1; on an edge with no transfer, s1_v SHALL become 0.
REQ-018 On each edge where s1_v is 1, the block SHALL set acc to acc XOR p(s1_a, s1_b) and increment cnt, which saturates at 2^CNT_W-1.
REQ-019 If cnt is already saturated when REQ-018 applies, the block SHALL set ovf to 1.
REQ-020 Back-to-back transfers SHALL be accepted at one beat per cycle with no bubbles.
REQ-021 On the edge where s1_v and s1_last are both 1, the FSM SHALL go from ACC to DONE.
REQ-022 On that same edge, out_y, out_count and out_ovf SHALL be registered with their post-update values.
REQ-023 out_valid SHALL rise at the second rising edge after the edge that transfers the last beat.
REQ-024 In DONE, out_y, out_count and out_ovf SHALL be held stable while out_valid is 1 and out_ready is 0.
REQ-025 In DONE, in_ready SHALL be 0.
REQ-026 On the output transfer edge, the block SHALL clear out_valid, clear acc, cnt and ovf, and return to ACC.
REQ-027 in_ready SHALL be 1 in the cycle after the output transfer, so the minimum turnaround from output transfer to the next input transfer is 1 cycle.
REQ-028 A burst SHALL always contain at least one beat; a single-beat burst gives out_y = p(a, b) and out_count = 1.
REQ-029 in_a, in_b and in_last SHALL be ignored on any edge without a transfer.
REQ-030 There SHALL be no combinational path from any input to any output.

Reset
REQ-031 While rst is 1 on an edge, the FSM SHALL enter ACC, and acc, cnt, ovf, s1_v, s1_a, s1_b and s1_last SHALL become 0.
REQ-032 While rst is 1 on an edge, out_valid, out_y, out_count and out_ovf SHALL become 0, and in_ready SHALL become 0.
REQ-033 in_ready SHALL rise on the first edge where rst is 0.
REQ-034 A reset asserted in the middle of a burst SHALL discard the partial burst, a beat held in s1, and any pending result; no out_valid pulse SHALL follow.

Verification
REQ-035 The bench SHALL cover a single-beat burst: a=0x03, b=0x03, last=1 -> out_y=0x05, out_count=1, out_ovf=0, with out_valid 2 edges after the transfer.
REQ-036 The bench SHALL cover truncation: a=0x80, b=0x02, last=1 -> out_y=0x00; a=0x0F, b=0x0F, last=1 -> out_y=0x55.
REQ-037 The bench SHALL cover a multi-beat burst with in_valid held high: beats (0x03,0x03), (0xFF,0x01), (0x0F,0x0F, last) -> out_y=0xAF, out_count=3, and no in_ready bubble before the last beat.
REQ-038 The bench SHALL cover backpressure: out_ready held at 0 for 5 cycles -> out_y and out_count stable and in_ready=0 throughout; out_ready=1 -> out_valid clears, and in_ready=1 on the next cycle.
REQ-039 The bench SHALL cover overflow with CNT_W=2: a burst of 5 beats of (0x01,0x01) -> out_count=3, out_ovf=1, out_y=0x01.
REQ-040 The bench SHALL cover reset mid-burst: 2 beats accepted, rst for 1 cycle, then (0x02,0x02, last) -> out_y=0x04, out_count=1.
